// File: rtl/ds_issue_queue.sv
// In-order decode-to-execute issue buffer with a counted per-register scoreboard.
// The head issues only when none of its sources has an outstanding writer.

module ds_sb_cnt #(
    parameter int CNT_WD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [CNT_WD-1:0] cnt
);
    // A same-cycle inc and dec cancel; a dec at zero is an upstream error and holds at zero.
    always_ff @(posedge clk) begin
        if (reset)                        cnt <= '0;
        else if (inc && !dec)             cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
    end
endmodule

module ds_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int BUS_WD = 155,
    parameter int CNT_WD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [BUS_WD-1:0]        in_bus,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic                     in_rs_used,
    input  logic                     in_rt_used,
    input  logic                     in_gr_we,
    input  logic [4:0]               in_dest,
    output logic                     out_valid,
    input  logic                     out_allowin,
    output logic [BUS_WD-1:0]        out_bus,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_dest,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [BUS_WD-1:0] bus;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic              rs_used;
        logic              rt_used;
        logic              gr_we;
        logic [4:0]        dest;
    } entry_t;

    entry_t                  mem [DEPTH];
    entry_t                  wr_ent;
    entry_t                  hd;
    logic [PW-1:0]           head, tail;
    logic [31:0][CNT_WD-1:0] sb;
    logic                    blocked, enq, iss;

    assign wr_ent = '{bus: in_bus, rs: in_rs, rt: in_rt, rs_used: in_rs_used,
                      rt_used: in_rt_used, gr_we: in_gr_we, dest: in_dest};
    assign hd     = mem[head];

    // Saturation guard keeps a further writer from wrapping its destination counter.
    assign blocked = (hd.rs_used && sb[hd.rs] != '0) ||
                     (hd.rt_used && sb[hd.rt] != '0) ||
                     (hd.gr_we && hd.dest != 5'd0 && sb[hd.dest] == '1);

    assign in_allowin = (count < FULL) && !flush;
    assign out_valid  = (count != '0) && !blocked && !flush;
    assign out_bus    = hd.bus;
    assign enq        = in_valid && in_allowin;
    assign iss        = out_valid && out_allowin;

    assign sb[0] = '0;
    for (genvar r = 1; r < 32; r++) begin : g_sb
        ds_sb_cnt #(.CNT_WD(CNT_WD)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (iss && hd.gr_we && hd.dest == 5'(r)),
            .dec   (wb_valid && wb_dest == 5'(r)),
            .cnt   (sb[r])
        );
    end

    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= wr_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (iss) head <= head + 1'b1;
            case ({enq, iss})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ds_issue_queue.sv
// Directed bench for ds_issue_queue: handshake flow, RAW stalls, full buffer,
// scoreboard counting, flush, register zero and saturation.

module tb_ds_issue_queue;
    logic         clk, reset;
    logic         in_valid, in_allowin;
    logic [154:0] in_bus;
    logic [4:0]   in_rs, in_rt, in_dest;
    logic         in_rs_used, in_rt_used, in_gr_we;
    logic         out_valid, out_allowin;
    logic [154:0] out_bus;
    logic         wb_valid;
    logic [4:0]   wb_dest;
    logic         flush;
    logic [2:0]   count;

    int n_chk  = 0;
    int n_pass = 0;

    ds_issue_queue #(.DEPTH(4), .BUS_WD(155), .CNT_WD(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_bus(in_bus),
        .in_rs(in_rs), .in_rt(in_rt), .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
        .in_gr_we(in_gr_we), .in_dest(in_dest),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_bus(out_bus),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [154:0] b, input logic [4:0] rs, input logic rs_u,
                         input logic [4:0] rt, input logic rt_u,
                         input logic we, input logic [4:0] dest);
        in_valid = 1'b1; in_bus = b;
        in_rs = rs; in_rs_used = rs_u; in_rt = rt; in_rt_used = rt_u;
        in_gr_we = we; in_dest = dest;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_bus = '0; in_rs = '0; in_rt = '0;
        in_rs_used = 1'b0; in_rt_used = 1'b0; in_gr_we = 1'b0; in_dest = '0;
    endtask

    task automatic do_reset();
        idle(); out_allowin = 1'b0; wb_valid = 1'b0; wb_dest = '0; flush = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle(); out_allowin = 1'b1; wb_valid = 1'b0; wb_dest = '0; flush = 1'b0;
        reset = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (in_allowin !== 1'b1) $display("FAIL rst_in_allowin got %b want 1", in_allowin); else n_pass++;
        n_chk++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
        reset = 1'b0;
        tick();
        n_chk++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL post_rst got v=%b c=%0d want v=0 c=0", out_valid, count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_allowin = 1'b1;
        offer(155'h303, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_no_bypass got %b want 0", out_valid); else n_pass++;
        tick();
        offer(155'h404, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4);
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h303) $display("FAIL b2b_first got v=%b bus=%h want v=1 bus=303", out_valid, out_bus); else n_pass++;
        n_chk++; if (count !== 3'd1) $display("FAIL b2b_count1 got %0d want 1", count); else n_pass++;
        tick();
        idle();
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h404) $display("FAIL b2b_second got v=%b bus=%h want v=1 bus=404", out_valid, out_bus); else n_pass++;
        n_chk++; if (count !== 3'd1) $display("FAIL b2b_count_peak got %0d want 1", count); else n_pass++;
        tick();
        n_chk++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL b2b_drained got c=%0d v=%b want c=0 v=0", count, out_valid); else n_pass++;
    endtask

    task automatic test_raw_stall();
        do_reset();
        out_allowin = 1'b1;
        offer(155'h501, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
        tick();
        offer(155'h502, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6);
        #1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL raw_writer_issue got %b want 1", out_valid); else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (out_valid !== 1'b0 || count !== 3'd1) $display("FAIL raw_stall%0d got v=%b c=%0d want v=0 c=1", i, out_valid, count); else n_pass++;
            tick();
        end
        wb_valid = 1'b1; wb_dest = 5'd5;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL raw_retire_cycle got %b want 0", out_valid); else n_pass++;
        tick();
        wb_valid = 1'b0; wb_dest = '0;
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h502) $display("FAIL raw_unblock got v=%b bus=%h want v=1 bus=502", out_valid, out_bus); else n_pass++;
        tick();
        n_chk++; if (count !== 3'd0) $display("FAIL raw_drained got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        out_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(155'(16'hF0 + i), 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            tick();
        end
        offer(155'hF4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        #1;
        n_chk++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else n_pass++;
        n_chk++; if (in_allowin !== 1'b0) $display("FAIL full_allowin got %b want 0", in_allowin); else n_pass++;
        out_allowin = 1'b1;
        #1;
        n_chk++; if (in_allowin !== 1'b0 || out_valid !== 1'b1 || out_bus !== 155'hF0) $display("FAIL full_issue got a=%b v=%b bus=%h want a=0 v=1 bus=f0", in_allowin, out_valid, out_bus); else n_pass++;
        tick();
        idle(); out_allowin = 1'b0;
        #1;
        n_chk++; if (count !== 3'd3 || out_bus !== 155'hF1) $display("FAIL full_after got c=%0d bus=%h want c=3 bus=f1", count, out_bus); else n_pass++;
        out_allowin = 1'b1;
        tick(); tick();
        n_chk++; if (out_bus !== 155'hF3 || count !== 3'd1) $display("FAIL full_last got c=%0d bus=%h want c=1 bus=f3", count, out_bus); else n_pass++;
        tick();
        n_chk++; if (count !== 3'd0) $display("FAIL full_5th_dropped got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_issue_retire();
        do_reset();
        out_allowin = 1'b1;
        offer(155'h701, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
        tick();
        offer(155'h702, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
        tick();
        offer(155'h703, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        wb_valid = 1'b1; wb_dest = 5'd7;
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h702) $display("FAIL ir_second_writer got v=%b bus=%h want v=1 bus=702", out_valid, out_bus); else n_pass++;
        tick();
        idle(); wb_valid = 1'b0; wb_dest = '0;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL ir_sb_kept got %b want 0", out_valid); else n_pass++;
        wb_valid = 1'b1; wb_dest = 5'd7;
        tick();
        wb_valid = 1'b0; wb_dest = '0;
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h703) $display("FAIL ir_one_retire got v=%b bus=%h want v=1 bus=703", out_valid, out_bus); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        out_allowin = 1'b1;
        offer(155'h901, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
        tick();
        idle();
        tick();
        out_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(155'(16'h910 + i), 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
            tick();
        end
        offer(155'h9FF, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        #1;
        n_chk++; if (count !== 3'd3 || out_valid !== 1'b1) $display("FAIL fl_pre got c=%0d v=%b want c=3 v=1", count, out_valid); else n_pass++;
        flush = 1'b1; out_allowin = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) $display("FAIL fl_during got v=%b a=%b want v=0 a=0", out_valid, in_allowin); else n_pass++;
        tick();
        flush = 1'b0; idle();
        #1;
        n_chk++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL fl_empty got c=%0d v=%b want c=0 v=0", count, out_valid); else n_pass++;
        offer(155'h920, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        n_chk++; if (out_valid !== 1'b0 || count !== 3'd1) $display("FAIL fl_sb_kept got v=%b c=%0d want v=0 c=1", out_valid, count); else n_pass++;
        wb_valid = 1'b1; wb_dest = 5'd9;
        tick();
        wb_valid = 1'b0; wb_dest = '0;
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'h920) $display("FAIL fl_after got v=%b bus=%h want v=1 bus=920", out_valid, out_bus); else n_pass++;
        tick();
    endtask

    task automatic test_zero_sat();
        do_reset();
        out_allowin = 1'b1;
        offer(155'hA00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
        tick();
        offer(155'hA01, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
        tick();
        offer(155'hA10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'hA01) $display("FAIL z_reader got v=%b bus=%h want v=1 bus=a01", out_valid, out_bus); else n_pass++;
        tick();
        offer(155'hA11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
        tick();
        offer(155'hA12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
        tick();
        offer(155'hA13, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_bus !== 155'hA12) $display("FAIL z_third_writer got v=%b bus=%h want v=1 bus=a12", out_valid, out_bus); else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (out_valid !== 1'b0 || out_bus !== 155'hA13) $display("FAIL z_sat_block%0d got v=%b bus=%h want v=0 bus=a13", i, out_valid, out_bus); else n_pass++;
            tick();
        end
        wb_valid = 1'b1; wb_dest = 5'd2;
        tick();
        wb_valid = 1'b0; wb_dest = '0;
        #1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL z_sat_release got %b want 1", out_valid); else n_pass++;
        tick();
        do_reset();
        out_allowin = 1'b1;
        offer(155'hA20, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL z_reset_clears_sb got %b want 1", out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_underflow();
        do_reset();
        out_allowin = 1'b1;
        wb_valid = 1'b1; wb_dest = 5'd6;
        tick();
        wb_valid = 1'b0; wb_dest = '0;
        offer(155'hB01, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL uf_no_wrap got %b want 1", out_valid); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_full();
        test_issue_retire();
        test_flush();
        test_zero_sat();
        test_underflow();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
